// File: rtl/mem_arb_pkg.sv
// Shared state encoding and constants for the instruction/data memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StResp  = 2'd2
    } arb_state_e;

    localparam logic OWN_IC = 1'b0;
    localparam logic OWN_DC = 1'b1;

    localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of data grants that bypassed a waiting instruction fetch.
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                inc_i,
    input  logic                clr_i,
    input  logic [STARVE_W-1:0] limit_i,
    output logic                at_limit_o
);

    logic [STARVE_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != limit_i)) begin
            cnt_d = cnt_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == limit_i);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one backing-memory port between icache and dcache, one transaction in flight,
// dcache first with a bounded number of bypasses of a waiting icache request.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ic_req_i,
    input  logic [ADDR_W-1:0]   ic_addr_i,
    output logic                ic_ack_o,
    output logic [DATA_W-1:0]   ic_rdata_o,
    input  logic                dc_req_i,
    input  logic [ADDR_W-1:0]   dc_addr_i,
    input  logic [DATA_W/8-1:0] dc_we_i,
    input  logic [DATA_W-1:0]   dc_din_i,
    output logic                dc_ack_o,
    output logic [DATA_W-1:0]   dc_rdata_o,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W/8-1:0] mem_we_o,
    output logic [DATA_W-1:0]   mem_din_o,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                stall_o
);

    localparam logic [STARVE_W-1:0] StarveLimit = STARVE_W'(STARVE_LIMIT);

    arb_state_e          state_q, state_d;
    logic                owner_q, owner_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W/8-1:0] mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   mem_din_q, mem_din_d;
    logic                ic_ack_q, ic_ack_d;
    logic                dc_ack_q, dc_ack_d;
    logic [DATA_W-1:0]   ic_rdata_q, ic_rdata_d;
    logic [DATA_W-1:0]   dc_rdata_q, dc_rdata_d;

    logic grant_ic, grant_dc;
    logic at_limit;

    // Arbitration is suppressed while an ack is on the wire so the acked requester,
    // whose req may still be high, cannot be re-granted on its old request.
    always_comb begin
        grant_ic = 1'b0;
        grant_dc = 1'b0;
        if ((state_q == StIdle) && !ic_ack_q && !dc_ack_q) begin
            if (dc_req_i && !(ic_req_i && at_limit)) begin
                grant_dc = 1'b1;
            end else if (ic_req_i) begin
                grant_ic = 1'b1;
            end
        end
    end

    mem_arb_starve_ctr u_starve_ctr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .inc_i      (grant_dc & ic_req_i),
        .clr_i      (grant_ic | ~ic_req_i),
        .limit_i    (StarveLimit),
        .at_limit_o (at_limit)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        mem_addr_d = mem_addr_q;
        mem_we_d   = mem_we_q;
        mem_din_d  = mem_din_q;
        ic_ack_d   = 1'b0;
        dc_ack_d   = 1'b0;
        ic_rdata_d = ic_rdata_q;
        dc_rdata_d = dc_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (grant_dc) begin
                    owner_d    = OWN_DC;
                    mem_addr_d = dc_addr_i;
                    mem_we_d   = dc_we_i;
                    mem_din_d  = dc_din_i;
                    state_d    = StIssue;
                end else if (grant_ic) begin
                    owner_d    = OWN_IC;
                    mem_addr_d = ic_addr_i;
                    mem_we_d   = '0;
                    mem_din_d  = '0;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                if (mem_req_ready_i) begin
                    if (mem_we_q != '0) begin
                        ic_ack_d = (owner_q == OWN_IC);
                        dc_ack_d = (owner_q == OWN_DC);
                        state_d  = StIdle;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                if (mem_rvalid_i) begin
                    if (owner_q == OWN_DC) begin
                        dc_rdata_d = mem_rdata_i;
                        dc_ack_d   = 1'b1;
                    end else begin
                        ic_rdata_d = mem_rdata_i;
                        ic_ack_d   = 1'b1;
                    end
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            owner_q    <= OWN_IC;
            mem_addr_q <= '0;
            mem_we_q   <= '0;
            mem_din_q  <= '0;
            ic_ack_q   <= 1'b0;
            dc_ack_q   <= 1'b0;
            ic_rdata_q <= '0;
            dc_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            mem_addr_q <= mem_addr_d;
            mem_we_q   <= mem_we_d;
            mem_din_q  <= mem_din_d;
            ic_ack_q   <= ic_ack_d;
            dc_ack_q   <= dc_ack_d;
            ic_rdata_q <= ic_rdata_d;
            dc_rdata_q <= dc_rdata_d;
        end
    end

    assign mem_req_valid_o = (state_q == StIssue);
    assign mem_addr_o      = mem_addr_q;
    assign mem_we_o        = mem_we_q;
    assign mem_din_o       = mem_din_q;
    assign ic_ack_o        = ic_ack_q;
    assign dc_ack_o        = dc_ack_q;
    assign ic_rdata_o      = ic_rdata_q;
    assign dc_rdata_o      = dc_rdata_q;
    assign stall_o         = (ic_req_i & ~ic_ack_q) | (dc_req_i & ~dc_ack_q);

endmodule
